// File: rtl/jtvigil_pkg.sv
// Shared types for the scroll-layer ROM requester: FSM state encoding and
// the layout of one tag-cache entry.
package jtvigil_pkg;

    // Tags are stored zero-extended to this width, so layer address widths up to 32 bits fit.
    localparam int TAG_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_W0   = 3'd2,
        ST_W1   = 3'd3,
        ST_FILL = 3'd4
    } romrq_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } cache_entry_t;

    function automatic cache_entry_t make_entry(input logic [TAG_W-1:0] tag,
                                                input logic [31:0]      data);
        cache_entry_t e;
        e.valid = 1'b1;
        e.tag   = tag;
        e.data  = data;
        return e;
    endfunction

endpackage

// File: rtl/jtvigil_romrq_cache.sv
// Two-entry tag cache for the scroll ROM requester: combinational hit/data
// lookup, LRU replacement and a single fill port driven by the requester FSM.
module jtvigil_romrq_cache
    import jtvigil_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_tag_i,
    input  logic [31:0]   fill_data_i,
    output logic          hit_o,
    output logic [31:0]   data_o
);

    cache_entry_t     e0_q;
    cache_entry_t     e1_q;
    logic             lru_q;
    logic [31:0]      hold_q;

    logic [TAG_W-1:0] tag_cmp;
    logic             match0;
    logic             match1;
    logic [31:0]      hit_data;

    // NOTE: every signal of this block gets a value before any condition, so no latch is inferred.
    always_comb begin
        tag_cmp  = TAG_W'(addr_i);
        match0   = e0_q.valid && (e0_q.tag == tag_cmp);
        match1   = e1_q.valid && (e1_q.tag == tag_cmp);
        hit_o    = cs_i && (match0 || match1);
        hit_data = match0 ? e0_q.data : e1_q.data;
        data_o   = hit_o ? hit_data : hold_q;
    end

    // NOTE: the two entries are plain flops, not a RAM, so they reset; clearing valid stops stale tags hitting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q   <= '0;
            e1_q   <= '0;
            lru_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            if (hit_o) begin
                hold_q <= hit_data;
            end
            // A fill owns the LRU bit: the new line becomes most recent.
            if (fill_i) begin
                if (lru_q) begin
                    e1_q <= make_entry(TAG_W'(fill_tag_i), fill_data_i);
                end else begin
                    e0_q <= make_entry(TAG_W'(fill_tag_i), fill_data_i);
                end
                lru_q <= ~lru_q;
            end else if (hit_o) begin
                lru_q <= match0;
            end
        end
    end

endmodule

// File: rtl/jtvigil_scr_romrq.sv
// Scroll-layer ROM requester: serves 32-bit layer fetches from a 2-entry
// cache and refills it with two-beat bursts on a 16-bit SDRAM slot.
module jtvigil_scr_romrq
    import jtvigil_pkg::*;
#(
    parameter int             AW     = 18,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = SDW'(22'h0)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic           rom_ok,
    output logic [31:0]    rom_data,
    output logic [SDW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           data_dst,
    input  logic [15:0]    sdram_din,
    output logic           busy
);

    romrq_state_e   state_q;
    logic [AW-1:0]  req_addr_q;
    logic [31:0]    buf_q;
    logic           sdram_req_q;
    logic [SDW-1:0] sdram_addr_q;
    logic           busy_q;

    logic [SDW-1:0] sdram_addr_d;
    logic           hit;
    logic           fill;

    // Each 32-bit layer word is two SDRAM words; the sum wraps within SDW bits.
    assign sdram_addr_d = OFFSET + SDW'({rom_addr, 1'b0});
    assign fill         = (state_q == ST_FILL);

    jtvigil_romrq_cache #(
        .AW (AW)
    ) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_i        (rom_cs),
        .addr_i      (rom_addr),
        .fill_i      (fill),
        .fill_tag_i  (req_addr_q),
        .fill_data_i (buf_q),
        .hit_o       (hit),
        .data_o      (rom_data)
    );

    // NOTE: state uses non-blocking assignments so every branch sees the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_addr_q   <= '0;
            buf_q        <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rom_cs && !hit) begin
                        req_addr_q   <= rom_addr;
                        sdram_addr_q <= sdram_addr_d;
                        sdram_req_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        state_q     <= ST_W0;
                    end
                end
                ST_W0: begin
                    if (data_dst) begin
                        buf_q[15:0] <= sdram_din;
                        state_q     <= ST_W1;
                    end
                end
                ST_W1: begin
                    if (data_dst) begin
                        buf_q[31:16] <= sdram_din;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    sdram_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_ok     = hit;
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_jtvigil_scr_romrq.sv
// Self-checking bench for jtvigil_scr_romrq: the bench plays the SDRAM arbiter
// and predicts every cycle from an MRU-ordered list model of the two-line cache.
module tb_jtvigil_scr_romrq;

    localparam logic [21:0] OFFSET_TB = 22'h0;

    typedef enum {PH_IDLE, PH_REQ, PH_BEAT, PH_FILL} phase_e;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        data_dst;
    logic [15:0] sdram_din;
    logic        busy;

    jtvigil_scr_romrq #(
        .AW     (18),
        .SDW    (22),
        .OFFSET (OFFSET_TB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_ok     (rom_ok),
        .rom_data   (rom_data),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .sdram_din  (sdram_din),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Cache model: list of up to two lines, index 0 is most recently used.
    logic [17:0] mt[2];
    logic [31:0] md[2];
    int          mn;
    logic [31:0] hold;

    // Arbiter / burst tracking
    phase_e      ph;
    int          wait_cnt, gap_cnt, nbeats;
    int          ack_wait, beat_gap;
    bit          rand_arb, spurious, fixed_en;
    logic [31:0] fixed_word, burst_word;
    logic [17:0] req_tag;
    logic [21:0] exp_addr, last_req_addr;

    bit          prev_req, obs_ok;
    logic [31:0] obs_data;
    int          req_seen;
    int          n_checks, n_errors;

    function automatic int model_find(input logic [17:0] a);
        for (int i = 0; i < mn; i++) begin
            if (mt[i] == a) return i;
        end
        return -1;
    endfunction

    task automatic model_touch(input int i);
        logic [17:0] t;
        logic [31:0] d;
        if (i == 1) begin
            t = mt[0]; d = md[0];
            mt[0] = mt[1]; md[0] = md[1];
            mt[1] = t; md[1] = d;
        end
    endtask

    task automatic model_fill(input logic [17:0] tag, input logic [31:0] data);
        mt[1] = mt[0]; md[1] = md[0];
        mt[0] = tag;   md[0] = data;
        if (mn < 2) mn++;
    endtask

    task automatic model_reset();
        mn = 0; mt[0] = '0; mt[1] = '0; md[0] = '0; md[1] = '0;
        hold = '0; ph = PH_IDLE; nbeats = 0; wait_cnt = 0; gap_cnt = 0;
        prev_req = 1'b0;
        sdram_ack = 1'b0; data_dst = 1'b0;
    endtask

    function automatic int pick_wait();
        return rand_arb ? int'($urandom_range(0, 3)) : ack_wait;
    endfunction

    function automatic int pick_gap();
        return rand_arb ? int'($urandom_range(0, 3)) : beat_gap;
    endfunction

    // One clock cycle, entered and left just after a rising edge.
    task automatic tick();
        int          hi;
        bit          exp_ok, ack_now, dst_now;
        logic [31:0] exp_data;
        ack_now   = 1'b0;
        dst_now   = 1'b0;
        sdram_din = 16'($urandom);
        case (ph)
            PH_REQ: begin
                if (wait_cnt == 0) ack_now = 1'b1;
                else wait_cnt--;
                if (spurious && $urandom_range(0, 2) == 0) dst_now = 1'b1;
            end
            PH_BEAT: begin
                if (gap_cnt == 0) begin
                    dst_now   = 1'b1;
                    sdram_din = (nbeats == 0) ? burst_word[15:0] : burst_word[31:16];
                end else begin
                    gap_cnt--;
                end
            end
            PH_IDLE: if (spurious && $urandom_range(0, 3) == 0) dst_now = 1'b1;
            default: ;
        endcase
        sdram_ack = ack_now;
        data_dst  = dst_now;

        @(negedge clk);
        hi       = model_find(rom_addr);
        exp_ok   = rom_cs && (hi >= 0);
        exp_data = exp_ok ? md[hi] : hold;
        n_checks++;
        if (rom_ok !== exp_ok) begin
            n_errors++;
            $display("FAIL rom_ok @%0t addr=%h: got %b expected %b", $time, rom_addr, rom_ok, exp_ok);
        end
        n_checks++;
        if (rom_data !== exp_data) begin
            n_errors++;
            $display("FAIL rom_data @%0t addr=%h: got %h expected %h", $time, rom_addr, rom_data, exp_data);
        end
        n_checks++;
        if (sdram_req !== (ph == PH_REQ)) begin
            n_errors++;
            $display("FAIL sdram_req @%0t: got %b expected %b", $time, sdram_req, ph == PH_REQ);
        end
        n_checks++;
        if (busy !== (ph != PH_IDLE)) begin
            n_errors++;
            $display("FAIL busy @%0t: got %b expected %b", $time, busy, ph != PH_IDLE);
        end
        if (ph == PH_REQ) begin
            n_checks++;
            if (sdram_addr !== exp_addr) begin
                n_errors++;
                $display("FAIL sdram_addr @%0t: got %h expected %h", $time, sdram_addr, exp_addr);
            end
        end
        if (sdram_req && !prev_req) begin
            req_seen++;
            last_req_addr = sdram_addr;
        end
        prev_req = sdram_req;
        obs_ok   = rom_ok;
        obs_data = rom_data;

        @(posedge clk);
        if (exp_ok) hold = md[hi];
        if (exp_ok && ph != PH_FILL) model_touch(hi);
        case (ph)
            PH_IDLE: begin
                if (rom_cs && hi < 0) begin
                    ph         = PH_REQ;
                    req_tag    = rom_addr;
                    exp_addr   = OFFSET_TB + {3'b000, rom_addr, 1'b0};
                    wait_cnt   = pick_wait();
                    burst_word = fixed_en ? fixed_word : $urandom;
                end
            end
            PH_REQ: begin
                if (ack_now) begin
                    ph      = PH_BEAT;
                    nbeats  = 0;
                    gap_cnt = pick_gap();
                end
            end
            PH_BEAT: begin
                if (dst_now) begin
                    nbeats++;
                    gap_cnt = pick_gap();
                    if (nbeats == 2) ph = PH_FILL;
                end
            end
            PH_FILL: begin
                model_fill(req_tag, burst_word);
                ph = PH_IDLE;
            end
            default: ;
        endcase
        #1;
    endtask

    task automatic wait_for_ok(input logic [17:0] a);
        int n;
        rom_cs   = 1'b1;
        rom_addr = a;
        n = 0;
        tick();
        while (!obs_ok && n < 60) begin
            tick();
            n++;
        end
        n_checks++;
        if (!obs_ok) begin
            n_errors++;
            $display("FAIL wait_ok_timeout addr=%h: got rom_ok %b expected 1", a, obs_ok);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rom_ok, rom_data, sdram_addr, sdram_req, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ok=%b data=%h addr=%h req=%b busy=%b expected all 0",
                     rom_ok, rom_data, sdram_addr, sdram_req, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_cold_miss();
        int n, base;
        fixed_en = 1'b1; fixed_word = 32'hDEADBEEF;
        ack_wait = 0; beat_gap = 0;
        base = req_seen;
        rom_cs = 1'b1; rom_addr = 18'h00010;
        tick();
        n = 0;
        while (!obs_ok && n < 20) begin
            tick();
            n++;
        end
        fixed_en = 1'b0;
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL cold_latency: got %0d cycles expected 5", n);
        end
        n_checks++;
        if (last_req_addr !== 22'h00020) begin
            n_errors++;
            $display("FAIL cold_sdram_addr: got %h expected 000020", last_req_addr);
        end
        n_checks++;
        if (obs_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL cold_data: got %h expected deadbeef", obs_data);
        end
        n_checks++;
        if (req_seen - base != 1) begin
            n_errors++;
            $display("FAIL cold_req_count: got %0d expected 1", req_seen - base);
        end
    endtask

    task automatic test_hit();
        int base;
        base = req_seen;
        rom_addr = 18'h00010;
        repeat (2) tick();
        n_checks++;
        if (obs_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL hit_repeat: got rom_ok %b expected 1", obs_ok);
        end
        wait_for_ok(18'h00011);
        rom_addr = 18'h00010;
        tick();
        n_checks++;
        if (obs_ok !== 1'b1 || obs_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL hit_return: got ok=%b data=%h expected ok=1 data=deadbeef", obs_ok, obs_data);
        end
        n_checks++;
        if (req_seen - base != 1) begin
            n_errors++;
            $display("FAIL hit_req_count: got %0d expected 1", req_seen - base);
        end
    endtask

    task automatic test_lru();
        int base;
        ack_wait = 1; beat_gap = 1;
        wait_for_ok(18'h1);
        wait_for_ok(18'h2);
        rom_addr = 18'h1;
        tick();
        wait_for_ok(18'h3);
        base = req_seen;
        rom_addr = 18'h1;
        repeat (3) tick();
        n_checks++;
        if (obs_ok !== 1'b1 || req_seen != base) begin
            n_errors++;
            $display("FAIL lru_keep: got ok=%b reqs=%0d expected ok=1 reqs=0", obs_ok, req_seen - base);
        end
        rom_addr = 18'h2;
        tick();
        n_checks++;
        if (obs_ok !== 1'b0) begin
            n_errors++;
            $display("FAIL lru_evict: got rom_ok %b expected 0", obs_ok);
        end
        tick();
        n_checks++;
        if (req_seen - base != 1 || last_req_addr !== 22'h4) begin
            n_errors++;
            $display("FAIL lru_refetch: got reqs=%0d addr=%h expected reqs=1 addr=000004",
                     req_seen - base, last_req_addr);
        end
        wait_for_ok(18'h2);
    endtask

    task automatic test_mid_burst_change();
        int n, base;
        ack_wait = 0; beat_gap = 2;
        base = req_seen;
        rom_cs = 1'b1; rom_addr = 18'h4;
        n = 0;
        while (!(ph == PH_BEAT && nbeats == 1) && n < 20) begin
            tick();
            n++;
        end
        rom_addr = 18'h5;
        n = 0;
        tick();
        while (!obs_ok && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (req_seen - base != 2 || last_req_addr !== 22'h0000A) begin
            n_errors++;
            $display("FAIL midburst_second_req: got reqs=%0d addr=%h expected reqs=2 addr=00000a",
                     req_seen - base, last_req_addr);
        end
        rom_addr = 18'h4;
        tick();
        n_checks++;
        if (obs_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL midburst_first_filled: got rom_ok %b expected 1", obs_ok);
        end
    endtask

    task automatic test_cs_gap();
        int n, base;
        ack_wait = 1; beat_gap = 3;
        base = req_seen;
        rom_cs = 1'b1; rom_addr = 18'h6;
        n = 0;
        while (ph != PH_BEAT && n < 20) begin
            tick();
            n++;
        end
        rom_cs = 1'b0;
        repeat (12) begin
            tick();
            n_checks++;
            if (obs_ok !== 1'b0) begin
                n_errors++;
                $display("FAIL csgap_ok_low: got rom_ok %b expected 0", obs_ok);
            end
        end
        rom_cs = 1'b1;
        tick();
        n_checks++;
        if (obs_ok !== 1'b1 || obs_data !== burst_word) begin
            n_errors++;
            $display("FAIL csgap_return: got ok=%b data=%h expected ok=1 data=%h", obs_ok, obs_data, burst_word);
        end
        n_checks++;
        if (req_seen - base != 1) begin
            n_errors++;
            $display("FAIL csgap_req_count: got %0d expected 1", req_seen - base);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n, base;
        ack_wait = 0; beat_gap = 4;
        rom_cs = 1'b1; rom_addr = 18'h7;
        n = 0;
        while (!(ph == PH_BEAT && nbeats == 1) && n < 20) begin
            tick();
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rom_ok, rom_data, sdram_addr, sdram_req, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_midburst: got ok=%b data=%h addr=%h req=%b busy=%b expected all 0",
                     rom_ok, rom_data, sdram_addr, sdram_req, busy);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = req_seen;
        wait_for_ok(18'h7);
        n_checks++;
        if (req_seen - base != 1 || last_req_addr !== 22'h0000E) begin
            n_errors++;
            $display("FAIL reset_refetch: got reqs=%0d addr=%h expected reqs=1 addr=00000e",
                     req_seen - base, last_req_addr);
        end
    endtask

    task automatic test_random();
        rand_arb = 1'b1; spurious = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rom_addr = ($urandom_range(0, 15) == 0) ? 18'($urandom) : 18'($urandom_range(0, 7));
            end
            rom_cs = ($urandom_range(0, 7) != 0);
            tick();
        end
        rom_cs = 1'b0;
        repeat (20) tick();
        rand_arb = 1'b0; spurious = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rom_cs = 1'b0; rom_addr = '0; sdram_din = '0;
        n_checks = 0; n_errors = 0; req_seen = 0;
        rand_arb = 1'b0; spurious = 1'b0; fixed_en = 1'b0; fixed_word = '0;
        ack_wait = 0; beat_gap = 0; burst_word = '0; req_tag = '0;
        exp_addr = '0; last_req_addr = '0; obs_ok = 1'b0; obs_data = '0;
        model_reset();
        test_reset();
        test_cold_miss();
        test_hit();
        test_lru();
        test_mid_burst_change();
        test_cs_gap();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
